prbs9_checker: RTL and testbench
================================

Name: prbs9_checker

Overview:
- Receive-side PRBS9 checker. It sits directly downstream of the PRBS9 generator, or after the channel/filter path that the generator feeds.
- It self-synchronises to the incoming 1-bit symbol stream (x[n] = x[n-9] ^ x[n-5]), declares lock, and then runs a local free-running replica.
- Once locked, it counts compared bits and bit errors for BER measurement, and drops lock when the error density exceeds a threshold.

Parameters:
- LOCK_THRESH, 32: consecutive correct predictions required in SEARCH to declare lock (1..255).
- UNLOCK_WIN, 64: length of the LOCKED error-density window, in valid symbols (2..65535).
- UNLOCK_ERRS, 8: errors within one window that force loss of lock (1..UNLOCK_WIN).
- CNT_W, 32: width of the bit and error counters.

Ports:
- clk  input  1  system clock, all state on rising edge.
- i_rst  input  1  reset. Asynchronous, active-high.
- i_valid  input  1  symbol strobe. i_symb is sampled only on edges where i_valid=1.
- i_symb  input  1  received PRBS9 symbol.
- i_clear  input  1  synchronous clear of o_bit_count/o_err_count. Does not affect lock state.
- o_lock  output  1  1 while in LOCKED.
- o_err  output  1  one-cycle pulse: mismatch detected on the sampled valid (LOCKED only).
- o_bit_count  output  CNT_W  symbols compared while LOCKED. Saturating.
- o_err_count  output  CNT_W  mismatches while LOCKED. Saturating.

Behaviour:
- Reset values:
  - hist[8:0]=0, state=SEARCH, fill=0, match=0, win_cnt=0, win_err=0.
  - o_lock=0, o_err=0, o_bit_count=0, o_err_count=0.
- Prediction is e = hist[0] ^ hist[4], where hist[k] holds x[n-9+k] relative to incoming x[n].
- All outputs are registered and update on the same edge that samples i_valid=1. Latency is 1 clock from the sampled symbol.
- When i_valid=0, all state holds and o_err=0.
- SEARCH state (per valid):
  - hist <= {i_symb, hist[8:1]}.
  - While fill<9: fill++, no compare.
  - Once fill=9: if i_symb==e and hist!=0, then match++. Otherwise match=0.
  - The hist=0 rule blocks false lock on an all-zero stream.
  - When the incrementing match reaches LOCK_THRESH: go to LOCKED, o_lock=1 on that edge, clear win_cnt and win_err.
- LOCKED state (per valid):
  - hist <= {e, hist[8:1]}. The local replica ignores i_symb, so each channel error is counted once, not tripled.
  - o_bit_count++.
  - If i_symb!=e: o_err=1, o_err_count++, win_err++.
  - win_cnt++.
  - If win_err (including this symbol) reaches UNLOCK_ERRS: go to SEARCH, o_lock=0, fill=0, match=0. Counters keep their values.
  - Else, when win_cnt reaches UNLOCK_WIN: win_cnt=0, win_err=0. Windows are back-to-back, not sliding.
- Counters saturate at 2^CNT_W-1 and never wrap.
- If i_clear and an increment occur on the same edge, i_clear wins and both counters read 0.
- Asynchronous reset mid-operation returns immediately to the reset values. Relock requires 9 + LOCK_THRESH valid symbols.
- A static one-sample offset of the input relative to the generator is irrelevant, because the checker is self-synchronising.

Test Plan:
- Generator (SEED 9'b110101010) feeds i_symb, i_valid=1 every cycle, reset released → o_lock rises on the 41st valid (9 fill + 32 matches). o_err_count stays 0 over 10000 symbols. o_bit_count equals valids since lock.
- Locked, invert one symbol → exactly one o_err pulse, o_err_count=1, o_lock stays 1, no further errors over the next 511 symbols.
- Locked, invert 8 symbols within one 64-symbol window → o_lock falls on the edge sampling the 8th error. Relock after 41 clean valids. Counters retain prior values.
- i_symb held 0 for 1000 valids → o_lock stays 0, o_bit_count=0. Switch to the generator stream → lock 41 valids later.
- i_valid asserted 1 cycle in 4, with i_clear pulsed while an error increment occurs → lock after 41 valids, independent of gaps. On the clear edge both counters read 0.
- i_rst asserted for 1 cycle while locked, with counters = 1000 → all outputs read 0 immediately (asynchronous). Lock reacquired 41 valids after release.
- Force o_bit_count near saturation (CNT_W=4 build): after 20 locked symbols o_bit_count=15 and holds.

Source files
------------

// File: rtl/prbs9_checker.sv
// PRBS9 receive checker: self-synchronising search, free-running replica
// once locked, saturating bit/error counters and windowed loss-of-lock.
module prbs9_checker #(
  parameter int LOCK_THRESH = 32,
  parameter int UNLOCK_WIN  = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_symb,
  input  logic             i_clear,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  localparam logic [7:0]  MATCH_END = 8'(LOCK_THRESH);
  localparam logic [15:0] WIN_END   = 16'(UNLOCK_WIN);
  localparam logic [15:0] ERR_END   = 16'(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state;
  logic [8:0]  hist;
  logic [3:0]  fill;
  logic [7:0]  match;
  logic [15:0] win_cnt;
  logic [15:0] win_err;

  logic             pred;
  logic             miss;
  logic             hist_nz;
  logic [7:0]       match_nx;
  logic [15:0]      win_cnt_nx;
  logic [15:0]      win_err_nx;
  logic [CNT_W-1:0] bit_sat;
  logic [CNT_W-1:0] err_sat;

  always_comb begin
    pred       = hist[0] ^ hist[4];
    miss       = i_symb ^ pred;
    hist_nz    = |hist;
    match_nx   = match + 8'd1;
    win_cnt_nx = win_cnt + 16'd1;
    win_err_nx = win_err + {15'd0, miss};
    bit_sat    = (o_bit_count == CNT_MAX) ? o_bit_count
                                          : o_bit_count + CNT_ONE;
    err_sat    = (o_err_count == CNT_MAX) ? o_err_count
                                          : o_err_count + CNT_ONE;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= SEARCH;
      hist        <= '0;
      fill        <= '0;
      match       <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      o_lock      <= 1'b0;
      o_err       <= 1'b0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else begin
      o_err <= 1'b0;
      if (i_valid) begin
        unique case (state)
          SEARCH: begin
            hist <= {i_symb, hist[8:1]};
            if (fill != 4'd9) begin
              fill <= fill + 4'd1;
            end else if (!miss && hist_nz) begin
              match <= match_nx;
              if (match_nx == MATCH_END) begin
                state   <= LOCKED;
                o_lock  <= 1'b1;
                win_cnt <= '0;
                win_err <= '0;
              end
            end else begin
              match <= '0;
            end
          end
          LOCKED: begin
            // replica free-runs so one channel error is seen only once
            hist        <= {pred, hist[8:1]};
            o_bit_count <= bit_sat;
            if (miss) begin
              o_err       <= 1'b1;
              o_err_count <= err_sat;
            end
            if (win_err_nx >= ERR_END) begin
              state   <= SEARCH;
              o_lock  <= 1'b0;
              fill    <= '0;
              match   <= '0;
              win_cnt <= '0;
              win_err <= '0;
            end else if (win_cnt_nx == WIN_END) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt_nx;
              win_err <= win_err_nx;
            end
          end
          default: state <= SEARCH;
        endcase
      end
      if (i_clear) begin
        o_bit_count <= '0;
        o_err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker against a queue-based behavioural
// model, with a narrow-counter second instance for saturation.
module tb_prbs9_checker;

  localparam int LT = 32;
  localparam int UW = 64;
  localparam int UE = 8;

  logic clk = 1'b0;
  logic i_rst, i_valid, i_symb, i_clear;
  logic lock_a, err_a, lock_b, err_b;
  logic [31:0] bits_a, errs_a;
  logic [3:0] bits_b, errs_b;

  always #5 clk = ~clk;

  prbs9_checker u_dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid),
    .i_symb(i_symb), .i_clear(i_clear),
    .o_lock(lock_a), .o_err(err_a),
    .o_bit_count(bits_a), .o_err_count(errs_a)
  );

  prbs9_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid),
    .i_symb(i_symb), .i_clear(i_clear),
    .o_lock(lock_b), .o_err(err_b),
    .o_bit_count(bits_b), .o_err_count(errs_b)
  );

  int n_err = 0;
  int n_chk = 0;
  bit run_cmp = 0;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  bit     m_lock, m_err;
  longint m_bits, m_errs;
  bit     q[$];
  int     m_match, m_wn, m_we;

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_err = 0; m_bits = 0; m_errs = 0;
    q.delete(); m_match = 0; m_wn = 0; m_we = 0;
    for (int i = 0; i < 9; i++) q.push_back(1'b0);
    q.delete();
  endtask

  task automatic model_step(bit v, bit s, bit clr);
    bit p, nz;
    m_err = 0;
    if (v) begin
      if (!m_lock) begin
        if (q.size() < 9) begin
          q.push_back(s);
        end else begin
          p = q[0] ^ q[4];
          nz = 0;
          foreach (q[i]) if (q[i]) nz = 1;
          if (s == p && nz) m_match++;
          else m_match = 0;
          q.push_back(s);
          void'(q.pop_front());
          if (m_match == LT) begin
            m_lock = 1; m_match = 0; m_wn = 0; m_we = 0;
          end
        end
      end else begin
        p = q[0] ^ q[4];
        q.push_back(p);
        void'(q.pop_front());
        m_bits++;
        if (s != p) begin
          m_err = 1; m_errs++; m_we++;
        end
        m_wn++;
        if (m_we >= UE) begin
          m_lock = 0; m_match = 0; q.delete();
        end else if (m_wn == UW) begin
          m_wn = 0; m_we = 0;
        end
      end
    end
    if (clr) begin
      m_bits = 0; m_errs = 0;
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("lock_a", lock_a, m_lock);
      chk("err_a", err_a, m_err);
      chk("bits_a", bits_a, sat(m_bits, 32));
      chk("errs_a", errs_a, sat(m_errs, 32));
      chk("lock_b", lock_b, m_lock);
      chk("err_b", err_b, m_err);
      chk("bits_b", bits_b, sat(m_bits, 4));
      chk("errs_b", errs_b, sat(m_errs, 4));
    end
  end

  // generator x[n] = x[n-9] ^ x[n-5]
  bit [8:0] g = 9'b110101010;

  function automatic bit gen_next();
    bit nb;
    nb = g[0] ^ g[4];
    g = {nb, g[8:1]};
    return nb;
  endfunction

  task automatic step(bit v, bit s, bit clr);
    @(negedge clk);
    i_valid = v; i_symb = s; i_clear = clr;
    @(posedge clk);
    model_step(v, s, clr);
    #1;
  endtask

  task automatic gstep(bit flip, bit clr);
    bit s;
    s = gen_next() ^ flip;
    step(1'b1, s, clr);
  endtask

  task automatic lock_run(input int gap, output int n);
    n = 0;
    while (!lock_a && n < 60) begin
      repeat (gap) step(1'b0, 1'b0, 1'b0);
      gstep(1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    i_valid = 0; i_symb = 0; i_clear = 0;
    #2 i_rst = 1;
    model_reset();
    #1;
    chk({name, "_lock"}, lock_a, 0);
    chk({name, "_err"}, err_a, 0);
    chk({name, "_bits"}, bits_a, 0);
    chk({name, "_errs"}, errs_a, 0);
    @(negedge clk);
    #2 i_rst = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst = 1; i_valid = 0; i_symb = 0; i_clear = 0;
    model_reset();
    do_reset("rst0");
    run_cmp = 1;

    lock_run(0, n);
    chk("lock_first", n, 41);
    for (int i = 0; i < 10000; i++) begin
      gstep(1'b0, 1'b0);
      if (i == 19) chk("sat_bits_b", bits_b, 15);
    end
    chk("clean_bits", bits_a, 10000);
    chk("clean_errs", errs_a, 0);

    for (int i = 0; i < 512; i++) begin
      gstep(i == 0, 1'b0);
      if (i == 0) chk("single_pulse", err_a, 1);
    end
    chk("single_errs", errs_a, 1);
    chk("single_lock", lock_a, 1);

    for (int i = 0; i < 8; i++) begin
      gstep(1'b1, 1'b0);
      if (i == 6) chk("hold_7th", lock_a, 1);
      if (i == 7) chk("drop_8th", lock_a, 0);
    end
    chk("keep_bits", bits_a, 10520);
    chk("keep_errs", errs_a, 9);
    lock_run(0, n);
    chk("relock", n, 41);
    chk("relock_bits", bits_a, 10520);
    chk("relock_errs", errs_a, 9);

    step(1'b0, 1'b0, 1'b1);
    chk("clear_bits", bits_a, 0);
    chk("clear_errs", errs_a, 0);
    for (int i = 0; i < 1000; i++) gstep(1'b0, 1'b0);
    chk("pre_rst_bits", bits_a, 1000);
    do_reset("rst_locked");
    lock_run(0, n);
    chk("lock_after_rst", n, 41);

    do_reset("rst_z");
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 1'b0);
    chk("zero_lock", lock_a, 0);
    chk("zero_bits", bits_a, 0);
    lock_run(0, n);
    chk("lock_after_zeros", (n <= 41 && lock_a) ? 1 : 0, 1);

    do_reset("rst_gap");
    lock_run(3, n);
    chk("lock_gap", n, 41);
    for (int i = 0; i < 5; i++) begin
      repeat (3) step(1'b0, 1'b0, 1'b0);
      gstep(1'b0, 1'b0);
    end
    chk("gap_bits", bits_a, 5);
    gstep(1'b1, 1'b1);
    chk("clr_err_pulse", err_a, 1);
    chk("clr_bits", bits_a, 0);
    chk("clr_errs", errs_a, 0);
    step(1'b0, 1'b0, 1'b0);

    run_cmp = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
